// File: rtl/sha_block_packer_if.sv
// Byte-in / block-out handshake bundle between the command FSM, the packer and the SHA core.
// The master side feeds bytes and acknowledges blocks. The slave side is the packer.
interface sha_block_packer_if #(
    parameter int NBYTES  = 64,
    parameter int BLOCK_W = 8 * NBYTES
);
    localparam int CNT_W = $clog2(NBYTES + 1);

    logic [7:0]         data_in;
    logic               data_ready;
    logic               clear;
    logic               block_ack;
    logic [BLOCK_W-1:0] sha_block;
    logic               block_ready;
    logic [CNT_W-1:0]   byte_count;
    logic               ready_for_byte;
    logic               overflow;

    modport master (
        output data_in, data_ready, clear, block_ack,
        input  sha_block, block_ready, byte_count, ready_for_byte, overflow
    );

    modport slave (
        input  data_in, data_ready, clear, block_ack,
        output sha_block, block_ready, byte_count, ready_for_byte, overflow
    );
endinterface

// File: rtl/sha_block_packer.sv
// Packs a stream of message bytes big-endian into one SHA message block.
// The finished block is held stable until the core acknowledges it.
module sha_block_packer #(
    parameter int NBYTES  = 64,
    parameter int BLOCK_W = 8 * NBYTES
) (
    input  logic              clk,
    input  logic              reset,
    sha_block_packer_if.slave bus
);
    localparam int CNT_W = $clog2(NBYTES + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NBYTES - 1);

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   w_count_nxt;
    logic               r_ovf;
    logic               w_ovf_nxt;
    logic               w_wr_en;
    logic [BLOCK_W-1:0] r_block;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= FILL;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_ovf   <= w_ovf_nxt;
        end
    end

    // Constant-index byte lanes: each lane is written only when the count points at it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_block <= '0;
        end else if (w_wr_en) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (r_count == CNT_W'(i)) begin
                    r_block[BLOCK_W-1-8*i -: 8] <= bus.data_in;
                end
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_ovf_nxt   = r_ovf;
        w_wr_en     = 1'b0;
        if (bus.clear) begin
            w_state_nxt = FILL;
            w_count_nxt = '0;
            w_ovf_nxt   = 1'b0;
        end else begin
            case (r_state)
                FILL: begin
                    if (bus.data_ready) begin
                        w_wr_en     = 1'b1;
                        w_count_nxt = r_count + CNT_W'(1);
                        if (r_count == LAST_IDX) begin
                            w_state_nxt = FULL;
                        end
                    end
                end
                FULL: begin
                    // A byte in FULL is dropped, even on the ack cycle.
                    if (bus.data_ready) begin
                        w_ovf_nxt = 1'b1;
                    end
                    if (bus.block_ack) begin
                        w_state_nxt = FILL;
                        w_count_nxt = '0;
                    end
                end
                default: begin
                    w_state_nxt = FILL;
                end
            endcase
        end
    end

    assign bus.sha_block      = r_block;
    assign bus.block_ready    = (r_state == FULL);
    assign bus.byte_count     = r_count;
    assign bus.ready_for_byte = (r_state == FILL);
    assign bus.overflow       = r_ovf;
endmodule

// File: doc/sha_block_packer.md
SHA_BLOCK_PACKER -- requirements
Module: sha_block_packer

Interface
REQ-001 The module SHALL have parameter NBYTES, default 64, giving the bytes per message block.
REQ-002 The module SHALL have parameter BLOCK_W, default 8*NBYTES (512), giving the block width in bits.
REQ-003 clk  input  1  single clock; every register SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 data_in  input  8  message byte from the command FSM (data_sha_in).
REQ-006 data_ready  input  1  one-cycle strobe; data_in is valid while high.
REQ-007 clear  input  1  synchronous abort of the block being assembled.
REQ-008 block_ack  input  1  SHA core has consumed sha_block.
REQ-009 sha_block  output  BLOCK_W  assembled 512-bit message block.
REQ-010 block_ready  output  1  sha_block is complete and stable.
REQ-011 byte_count  output  7  bytes held in the current block, range 0..64.
REQ-012 ready_for_byte  output  1  high when the block accepts bytes (state FILL).
REQ-013 overflow  output  1  sticky flag: a byte arrived while the block was FULL.

Function
REQ-014 The block SHALL implement exactly two states, FILL and FULL; ready_for_byte SHALL equal (state==FILL).
REQ-015 FILL, data_ready=1: the byte SHALL be written to bits [BLOCK_W-1-8*byte_count -: 8] (big-endian; byte 0 to [511:504]) and byte_count SHALL increment by 1 on the same edge.
REQ-016 FILL, data_ready=0: sha_block and byte_count SHALL hold.
REQ-017 Accepting byte index NBYTES-1 SHALL set state=FULL, byte_count=64 and block_ready=1 on that same edge, so block_ready is visible one cycle after the last strobe.
REQ-018 FULL: block_ready SHALL stay 1 and sha_block SHALL stay bit-stable until block_ack is sampled high.
REQ-019 FULL, block_ack=1: the next edge SHALL give state=FILL, block_ready=0 and byte_count=0; sha_block SHALL keep its old contents until they are overwritten.
REQ-020 block_ack in FILL SHALL be ignored.
REQ-021 data_ready in FULL (including the ack cycle) SHALL drop the byte and set overflow=1; sha_block and byte_count SHALL be unchanged.
REQ-022 overflow SHALL be cleared only by reset or clear.
REQ-023 clear=1 SHALL on the next edge force state=FILL, byte_count=0, block_ready=0 and overflow=0; sha_block SHALL hold.
REQ-024 clear SHALL take priority over data_ready and block_ack in the same cycle.
REQ-025 byte_count SHALL never exceed 64 or wrap to 0 except via block_ack, clear or reset.
REQ-026 The block SHALL be able to accept back-to-back data_ready strobes on every cycle in FILL with no bytes lost.

Reset
REQ-027 Reset SHALL have priority over clear, data_ready and block_ack.
REQ-028 After reset: state=FILL, sha_block=0, block_ready=0, byte_count=0, ready_for_byte=1, overflow=0.
REQ-029 Reset asserted mid-block or in FULL SHALL discard the partial or complete block with no output glitch beyond the reset values.

Verification
REQ-030 Strobe 64 consecutive bytes 0x00..0x3F -> one cycle after the last strobe: block_ready=1, byte_count=64, sha_block[511:504]=0x00, sha_block[7:0]=0x3F.
REQ-031 Strobe 64 bytes 0xA5 with one idle cycle between strobes, then hold block_ack=0 for 10 cycles -> block_ready stays 1 and sha_block stays all 0xA5 throughout.
REQ-032 In FULL, data_ready=1 with data_in=0xFF -> overflow=1, sha_block unchanged; then clear -> overflow=0, byte_count=0, block_ready=0.
REQ-033 In FULL, block_ack=1 and data_ready=1 in the same cycle -> next cycle state=FILL, byte_count=0, overflow=1, byte not stored.
REQ-034 After 20 bytes, assert reset -> next cycle byte_count=0, sha_block=0; a following 64-byte burst completes normally.
REQ-035 After 30 bytes, assert clear with data_ready=1 -> byte_count=0; a full new block then starts at sha_block[511:504].
